// File: rtl/csi2_pkt_scheduler.sv
// CSI-2 packet scheduler: arbitrates short/long packet requests, drives the D-PHY
// HS request handshake and emits header+ECC, payload and CRC-16 as a byte stream.
module csi2_pkt_scheduler #(
    parameter logic [1:0] VC       = 2'd0,
    parameter logic [7:0] ERR_FILL = 8'h00
) (
    input  logic        byteclk,
    input  logic        max10_resetn,
    input  logic        sp_req,
    input  logic [5:0]  sp_dt,
    input  logic [15:0] sp_data,
    output logic        sp_ack,
    input  logic        lp_req,
    input  logic [5:0]  lp_dt,
    input  logic [15:0] lp_wc,
    output logic        lp_ack,
    input  logic [7:0]  pl_data,
    input  logic        pl_valid,
    output logic        pl_rd,
    output logic        phy_hs_req,
    input  logic        phy_hs_rdy,
    input  logic        phy_idle,
    output logic [7:0]  phy_data,
    output logic        phy_valid,
    output logic        busy,
    output logic        err_underrun,
    input  logic        err_clr
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        HDR,
        PAYLOAD,
        CRC,
        WAIT_IDLE
    } state_t;

    state_t      state;
    logic [1:0]  idx;
    logic        is_long;
    logic [5:0]  dt_q;
    logic [15:0] wc_q;
    logic [15:0] cnt;
    logic [15:0] crc;
    logic        sot_seen;
    logic        load_pl;
    logic [7:0]  pl_byte;

    function automatic logic [7:0] hdr_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^ d[16]
             ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^ d[17]
             ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^ d[18]
             ^ d[20] ^ d[21] ^ d[22];
        p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^ d[19]
             ^ d[20] ^ d[21] ^ d[23];
        p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^ d[19]
             ^ d[20] ^ d[22] ^ d[23];
        p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^ d[18]
             ^ d[19] ^ d[21] ^ d[22] ^ d[23];
        return {2'b00, p};
    endfunction

    // Byte-parallel form of the reflected 0x8408 CRC (LSB-first, one byte per call).
    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [7:0] x;
        x = b ^ c[7:0];
        x = x ^ {x[3:0], 4'h0};
        return {x, c[15:8]} ^ {12'h000, x[7:4]} ^ {5'b00000, x, 3'b000};
    endfunction

    // Payload bytes are loaded on the same edge that leaves the previous byte on the bus.
    assign load_pl = ((state == HDR) && (idx == 2'd3) && is_long && (wc_q != 16'd0))
                  || ((state == PAYLOAD) && (cnt != wc_q - 16'd1));
    assign pl_byte = pl_valid ? pl_data : ERR_FILL;
    assign pl_rd   = load_pl & pl_valid;
    assign busy    = (state != IDLE);

    always_ff @(posedge byteclk or negedge max10_resetn) begin
        if (!max10_resetn) begin
            state        <= IDLE;
            idx          <= '0;
            is_long      <= 1'b0;
            dt_q         <= '0;
            wc_q         <= '0;
            cnt          <= '0;
            crc          <= '1;
            sot_seen     <= 1'b0;
            sp_ack       <= 1'b0;
            lp_ack       <= 1'b0;
            phy_hs_req   <= 1'b0;
            phy_valid    <= 1'b0;
            phy_data     <= '0;
            err_underrun <= 1'b0;
        end else begin
            sp_ack <= 1'b0;
            lp_ack <= 1'b0;

            if (load_pl && !pl_valid)
                err_underrun <= 1'b1;
            else if (err_clr)
                err_underrun <= 1'b0;

            if (load_pl) begin
                phy_data <= pl_byte;
                crc      <= crc_upd(crc, pl_byte);
            end

            if (state != IDLE && (!phy_idle || phy_hs_rdy))
                sot_seen <= 1'b1;

            case (state)
                IDLE: begin
                    if (phy_idle && sp_req) begin
                        sp_ack     <= 1'b1;
                        dt_q       <= sp_dt;
                        wc_q       <= sp_data;
                        is_long    <= 1'b0;
                        sot_seen   <= 1'b0;
                        phy_hs_req <= 1'b1;
                        state      <= WAIT_RDY;
                    end else if (phy_idle && lp_req) begin
                        lp_ack     <= 1'b1;
                        dt_q       <= lp_dt;
                        wc_q       <= lp_wc;
                        is_long    <= 1'b1;
                        sot_seen   <= 1'b0;
                        phy_hs_req <= 1'b1;
                        state      <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (phy_hs_rdy) begin
                        phy_data  <= {VC, dt_q};
                        phy_valid <= 1'b1;
                        idx       <= '0;
                        state     <= HDR;
                    end
                end
                HDR: begin
                    case (idx)
                        2'd0: phy_data <= wc_q[7:0];
                        2'd1: phy_data <= wc_q[15:8];
                        2'd2: phy_data <= hdr_ecc({wc_q, VC, dt_q});
                        default: ;
                    endcase
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        if (!is_long) begin
                            phy_valid  <= 1'b0;
                            phy_hs_req <= 1'b0;
                            state      <= WAIT_IDLE;
                        end else if (wc_q == 16'd0) begin
                            phy_data <= crc[7:0];
                            idx      <= '0;
                            state    <= CRC;
                        end else begin
                            cnt   <= '0;
                            state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (cnt == wc_q - 16'd1) begin
                        phy_data <= crc[7:0];
                        idx      <= '0;
                        state    <= CRC;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                CRC: begin
                    if (idx == 2'd0) begin
                        phy_data <= crc[15:8];
                        idx      <= 2'd1;
                    end else begin
                        phy_valid  <= 1'b0;
                        phy_hs_req <= 1'b0;
                        crc        <= '1;
                        state      <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    // LP-11 must have been left (SoT) before its return counts as end of burst.
                    if (sot_seen && phy_idle)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csi2_pkt_scheduler.sv
// Directed bench for csi2_pkt_scheduler: a PHY/FIFO model drives the DUT and a
// packet-level model predicts every byte on the HS stream.
`timescale 1ns/1ps
module tb_csi2_pkt_scheduler;

    typedef logic [7:0] bq_t[$];

    logic        byteclk = 1'b0;
    logic        max10_resetn = 1'b0;
    logic        sp_req = 1'b0;
    logic [5:0]  sp_dt = '0;
    logic [15:0] sp_data = '0;
    logic        sp_ack;
    logic        lp_req = 1'b0;
    logic [5:0]  lp_dt = '0;
    logic [15:0] lp_wc = '0;
    logic        lp_ack;
    logic [7:0]  pl_data = '0;
    logic        pl_valid = 1'b0;
    logic        pl_rd;
    logic        phy_hs_req;
    logic        phy_hs_rdy = 1'b0;
    logic        phy_idle = 1'b1;
    logic [7:0]  phy_data;
    logic        phy_valid;
    logic        busy;
    logic        err_underrun;
    logic        err_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 byteclk = ~byteclk;

    csi2_pkt_scheduler #(.VC(2'd0), .ERR_FILL(8'h00)) dut (
        .byteclk(byteclk), .max10_resetn(max10_resetn),
        .sp_req(sp_req), .sp_dt(sp_dt), .sp_data(sp_data), .sp_ack(sp_ack),
        .lp_req(lp_req), .lp_dt(lp_dt), .lp_wc(lp_wc), .lp_ack(lp_ack),
        .pl_data(pl_data), .pl_valid(pl_valid), .pl_rd(pl_rd),
        .phy_hs_req(phy_hs_req), .phy_hs_rdy(phy_hs_rdy), .phy_idle(phy_idle),
        .phy_data(phy_data), .phy_valid(phy_valid), .busy(busy),
        .err_underrun(err_underrun), .err_clr(err_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: Hamming column code of each header bit, XORed over the set bits.
    localparam logic [5:0] ECC_COL [0:23] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

    function automatic logic [7:0] m_ecc(input logic [23:0] d);
        logic [5:0] s;
        s = '0;
        for (int i = 0; i < 24; i++)
            if (d[i]) s = s ^ ECC_COL[i];
        return {2'b00, s};
    endfunction

    function automatic logic [15:0] m_crc(input bq_t b);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (b[i])
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[i][k];
                c  = c >> 1;
                if (fb) c = c ^ 16'h8408;
            end
        return c;
    endfunction

    // Payload FIFO model (FWFT) with an optional stall window after a given pop count.
    bq_t fifo_q;
    bq_t m_pl;
    int  pops = 0;
    int  stall_at = -1;
    int  stall_len = 0;
    int  stall_left = 0;
    bit  stall_done = 1'b0;

    task automatic fifo_drive();
        pl_valid = (fifo_q.size() != 0) && (stall_left == 0);
        pl_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic load_fifo(input bq_t b, input int s_at, input int s_len);
        fifo_q     = b;
        m_pl       = b;
        pops       = 0;
        stall_at   = s_at;
        stall_len  = s_len;
        stall_left = 0;
        stall_done = 1'b0;
        fifo_drive();
    endtask

    initial begin
        logic rd_s;
        forever begin
            @(negedge byteclk);
            rd_s = pl_rd;
            @(posedge byteclk);
            #1;
            if (rd_s) begin
                if (fifo_q.size() != 0) void'(fifo_q.pop_front());
                pops++;
            end
            if (stall_left > 0)
                stall_left--;
            else if (!stall_done && stall_at >= 0 && pops == stall_at) begin
                stall_left = stall_len;
                stall_done = 1'b1;
            end
            fifo_drive();
        end
    end

    // PHY model: leaves LP-11 on request, reports HS ready after rdy_delay cycles,
    // trails back to LP-11 idle_delay cycles after the request drops.
    int rdy_delay = 3;
    int idle_delay = 3;
    initial begin
        logic req_s;
        int   cnt;
        bit   hs;
        cnt = 0;
        hs  = 1'b0;
        forever begin
            @(negedge byteclk);
            req_s = phy_hs_req;
            @(posedge byteclk);
            #1;
            if (!hs) begin
                if (req_s) begin
                    phy_idle = 1'b0;
                    cnt++;
                    if (cnt >= rdy_delay) begin
                        phy_hs_rdy = 1'b1;
                        hs = 1'b1;
                        cnt = 0;
                    end
                end else if (!phy_idle) begin
                    cnt++;
                    if (cnt >= idle_delay) begin
                        phy_idle = 1'b1;
                        cnt = 0;
                    end
                end
            end else if (!req_s) begin
                phy_hs_rdy = 1'b0;
                hs = 1'b0;
                cnt = 0;
            end
        end
    end

    // Scoreboard
    logic [7:0] exp_q[$];
    int  len_q[$];
    int  remaining = 0;
    bit  chk_en = 1'b0;
    bq_t cap_q;
    bit  prev_valid = 1'b0;
    bit  rdy_d1 = 1'b0;
    bit  rdy_d2 = 1'b0;
    bit  idle_prev = 1'b1;
    int  cyc = 0;
    int  idle_rise_cyc = 0;
    int  sp_ack_cyc = 0;
    int  lp_ack_cyc = 0;
    int  lp_gap = 0;
    int  sp_ack_cnt = 0;

    task automatic push_short();
        logic [7:0] di;
        di = {2'b00, sp_dt};
        exp_q.push_back(di);
        exp_q.push_back(sp_data[7:0]);
        exp_q.push_back(sp_data[15:8]);
        exp_q.push_back(m_ecc({sp_data, di}));
        len_q.push_back(4);
    endtask

    task automatic push_long();
        logic [7:0] di;
        bq_t        pl;
        logic [15:0] c;
        di = {2'b00, lp_dt};
        for (int k = 0; k < int'(lp_wc); k++) begin
            if (stall_at >= 0 && k >= stall_at && k < stall_at + stall_len)
                pl.push_back(8'h00);
            else if (m_pl.size() != 0)
                pl.push_back(m_pl.pop_front());
            else
                pl.push_back(8'h00);
        end
        c = m_crc(pl);
        exp_q.push_back(di);
        exp_q.push_back(lp_wc[7:0]);
        exp_q.push_back(lp_wc[15:8]);
        exp_q.push_back(m_ecc({lp_wc, di}));
        foreach (pl[i]) exp_q.push_back(pl[i]);
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
        len_q.push_back(int'(lp_wc) + 6);
    endtask

    initial begin
        forever begin
            @(negedge byteclk);
            cyc++;
            if (phy_idle && !idle_prev) idle_rise_cyc = cyc;
            if (chk_en) begin
                if (sp_ack) begin
                    sp_ack_cnt++;
                    sp_ack_cyc = cyc;
                    chk("single_ack", {31'd0, lp_ack}, 32'd0);
                    push_short();
                end
                if (lp_ack) begin
                    lp_ack_cyc = cyc;
                    lp_gap = cyc - idle_rise_cyc;
                    chk("sp_priority_at_lp_ack", {31'd0, sp_req}, 32'd0);
                    push_long();
                end
                if (phy_valid) begin
                    cap_q.push_back(phy_data);
                    if (remaining == 0) begin
                        if (len_q.size() == 0)
                            chk("unexpected_byte", {31'd0, phy_valid}, 32'd0);
                        else begin
                            remaining = len_q.pop_front();
                            chk("rdy_to_first_byte", {30'd0, rdy_d2, rdy_d1}, 32'd1);
                        end
                    end
                    if (remaining > 0) begin
                        chk("stream_byte", {24'd0, phy_data}, {24'd0, exp_q.pop_front()});
                        remaining--;
                    end
                end else begin
                    if (remaining > 0) begin
                        chk("stream_gap", {31'd0, phy_valid}, 32'd1);
                        for (int k = 0; k < remaining; k++) void'(exp_q.pop_front());
                        remaining = 0;
                    end
                    if (prev_valid)
                        chk("hs_req_drop_after_last", {31'd0, phy_hs_req}, 32'd0);
                end
                prev_valid = phy_valid;
            end
            idle_prev = phy_idle;
            rdy_d2 = rdy_d1;
            rdy_d1 = phy_hs_rdy;
        end
    end

    task automatic request_sp(input logic [5:0] dt, input logic [15:0] d);
        bit got;
        got = 1'b0;
        @(posedge byteclk);
        #1;
        sp_dt = dt;
        sp_data = d;
        sp_req = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge byteclk);
            if (sp_ack) got = 1'b1;
        end
        if (!got) chk("sp_ack_timeout", 32'd0, 32'd1);
        @(posedge byteclk);
        #1;
        sp_req = 1'b0;
    endtask

    task automatic request_lp(input logic [5:0] dt, input logic [15:0] wc);
        bit got;
        got = 1'b0;
        @(posedge byteclk);
        #1;
        lp_dt = dt;
        lp_wc = wc;
        lp_req = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge byteclk);
            if (lp_ack) got = 1'b1;
        end
        if (!got) chk("lp_ack_timeout", 32'd0, 32'd1);
        @(posedge byteclk);
        #1;
        lp_req = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge byteclk);
            if (!busy && remaining == 0 && len_q.size() == 0) done = 1'b1;
        end
        if (!done) chk(name, 32'd0, 32'd1);
    endtask

    task automatic cap_chk(input string name, input int idx, input logic [7:0] exp);
        chk(name, (idx < cap_q.size()) ? {24'd0, cap_q[idx]} : 32'hFFFF_FFFF, {24'd0, exp});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bq_t v24;
        bq_t v;
        int  n;
        v24 = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72, 8'hBB, 8'hD4, 8'hB8, 8'h5A,
                8'hC8, 8'h75, 8'hC2, 8'h7C, 8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};

        // Pin the model against hand-computed values.
        chk("model_ecc_fs", {24'd0, m_ecc(24'h000100)}, 32'h1A);
        chk("model_ecc_raw8_24", {24'd0, m_ecc(24'h00182A)}, 32'h13);
        chk("model_crc_24", {16'd0, m_crc(v24)}, 32'h00F0);
        v.delete();
        chk("model_crc_empty", {16'd0, m_crc(v)}, 32'hFFFF);

        // Reset state
        repeat (3) @(negedge byteclk);
        chk("rst_sp_ack", {31'd0, sp_ack}, 32'd0);
        chk("rst_lp_ack", {31'd0, lp_ack}, 32'd0);
        chk("rst_pl_rd", {31'd0, pl_rd}, 32'd0);
        chk("rst_hs_req", {31'd0, phy_hs_req}, 32'd0);
        chk("rst_valid", {31'd0, phy_valid}, 32'd0);
        chk("rst_data", {24'd0, phy_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err_underrun}, 32'd0);
        max10_resetn = 1'b1;
        chk_en = 1'b1;

        // FS, sp_data 0001
        cap_q.delete();
        request_sp(6'h00, 16'h0001);
        wait_done("fs_done_timeout");
        chk("fs_len", cap_q.size(), 32'd4);
        cap_chk("fs_b0", 0, 8'h00);
        cap_chk("fs_b1", 1, 8'h01);
        cap_chk("fs_b2", 2, 8'h00);
        cap_chk("fs_ecc", 3, 8'h1A);
        chk("fs_ack_pulses", sp_ack_cnt, 32'd1);

        // Long RAW8, wc=24
        cap_q.delete();
        load_fifo(v24, -1, 0);
        request_lp(6'h2A, 16'd24);
        wait_done("raw8_done_timeout");
        chk("raw8_len", cap_q.size(), 32'd30);
        cap_chk("raw8_di", 0, 8'h2A);
        cap_chk("raw8_wcl", 1, 8'h18);
        cap_chk("raw8_ecc", 3, 8'h13);
        cap_chk("raw8_crc_lo", 28, 8'hF0);
        cap_chk("raw8_crc_hi", 29, 8'h00);
        chk("raw8_pops", pops, 32'd24);

        // Simultaneous short and long requests
        cap_q.delete();
        v = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        load_fifo(v, -1, 0);
        fork
            request_sp(6'h02, 16'h0005);
            request_lp(6'h2A, 16'd4);
        join
        wait_done("prio_done_timeout");
        chk("prio_sp_first", {31'd0, sp_ack_cyc < lp_ack_cyc}, 32'd1);
        chk("prio_lp_after_idle", {31'd0, lp_gap >= 1 && lp_gap <= 4}, 32'd1);
        chk("prio_len", cap_q.size(), 32'd14);
        cap_chk("prio_first_di", 0, 8'h02);

        // Underrun on payload bytes 3-4 of 8
        cap_q.delete();
        v = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        load_fifo(v, 2, 2);
        chk("err_clear_before", {31'd0, err_underrun}, 32'd0);
        request_lp(6'h2A, 16'd8);
        wait_done("underrun_done_timeout");
        chk("underrun_len", cap_q.size(), 32'd14);
        cap_chk("underrun_fill3", 6, 8'h00);
        cap_chk("underrun_fill4", 7, 8'h00);
        cap_chk("underrun_next", 8, 8'h33);
        chk("underrun_pops", pops, 32'd6);
        chk("underrun_err_set", {31'd0, err_underrun}, 32'd1);

        // wc=0 long packet
        cap_q.delete();
        v.delete();
        load_fifo(v, -1, 0);
        request_lp(6'h2A, 16'd0);
        wait_done("wc0_done_timeout");
        chk("wc0_len", cap_q.size(), 32'd6);
        cap_chk("wc0_crc_lo", 4, 8'hFF);
        cap_chk("wc0_crc_hi", 5, 8'hFF);
        chk("wc0_pops", pops, 32'd0);
        chk("err_sticky", {31'd0, err_underrun}, 32'd1);
        @(posedge byteclk);
        #1 err_clr = 1'b1;
        @(posedge byteclk);
        #1 err_clr = 1'b0;
        @(negedge byteclk);
        chk("err_cleared", {31'd0, err_underrun}, 32'd0);

        // Reset during payload
        v.delete();
        for (int i = 0; i < 40; i++) v.push_back(8'(i + 1));
        load_fifo(v, -1, 0);
        request_lp(6'h2A, 16'd40);
        n = 0;
        while (pops < 5 && n < 200) begin
            @(negedge byteclk);
            n++;
        end
        chk("reset_reach_payload", {31'd0, pops >= 5}, 32'd1);
        @(negedge byteclk);
        chk_en = 1'b0;
        #2 max10_resetn = 1'b0;
        #1;
        chk("rst_mid_hs_req", {31'd0, phy_hs_req}, 32'd0);
        chk("rst_mid_valid", {31'd0, phy_valid}, 32'd0);
        chk("rst_mid_pl_rd", {31'd0, pl_rd}, 32'd0);
        repeat (3) @(negedge byteclk);
        exp_q.delete();
        len_q.delete();
        remaining = 0;
        prev_valid = 1'b0;
        v.delete();
        load_fifo(v, -1, 0);
        max10_resetn = 1'b1;
        @(negedge byteclk);
        chk("rst_release_busy", {31'd0, busy}, 32'd0);
        chk_en = 1'b1;
        cap_q.delete();
        request_sp(6'h01, 16'h0002);
        wait_done("post_reset_done_timeout");
        chk("post_reset_len", cap_q.size(), 32'd4);
        cap_chk("post_reset_di", 0, 8'h01);
        cap_chk("post_reset_ecc", 3, 8'h1B);

        repeat (2) @(negedge byteclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
